// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode drives rf read ports, decoded fields are
// registered to line up with the rf's registered read data; handles load-use bubbles.
module decode_stage #(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_valid,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   output logic            if_ready,
   input  logic            flush,
   input  logic            ex_stall,
   output logic [4:0]      rf_p0_addr,
   output logic [4:0]      rf_p1_addr,
   output logic            rf_re0,
   output logic            rf_re1,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [4:0]      ex_rd,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [31:0]     ex_imm,
   output logic [4:0]      ex_opcode,
   output logic [2:0]      ex_funct3,
   output logic            ex_funct7b5,
   output logic            ex_is_load,
   output logic            ex_illegal
);

   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_FENCE  = 5'b00011;
   localparam logic [4:0] OP_IMM    = 5'b00100;
   localparam logic [4:0] OP_AUIPC  = 5'b00101;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_OP     = 5'b01100;
   localparam logic [4:0] OP_LUI    = 5'b01101;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_SYSTEM = 5'b11100;

   logic [4:0]  opc, rs1, rs2, rd;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
   logic        legal, uses_rs1, uses_rs2, is_load, has_rd;
   logic        hz;

   assign opc = if_instr[6:2];
   assign rs1 = if_instr[19:15];
   assign rs2 = if_instr[24:20];
   assign rd  = if_instr[11:7];

   assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
   assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
   assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                   if_instr[11:8], 1'b0};
   assign imm_u = {if_instr[31:12], 12'h000};
   assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                   if_instr[30:21], 1'b0};

   always_comb begin
      legal    = 1'b0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      is_load  = 1'b0;
      has_rd   = 1'b0;
      imm      = 32'h0;
      if (if_instr[1:0] == 2'b11) begin
         case (opc)
            OP_LUI, OP_AUIPC: begin legal = 1'b1; has_rd = 1'b1; imm = imm_u; end
            OP_JAL:           begin legal = 1'b1; has_rd = 1'b1; imm = imm_j; end
            OP_JALR, OP_IMM:  begin legal = 1'b1; has_rd = 1'b1; uses_rs1 = 1'b1; imm = imm_i; end
            OP_LOAD: begin
               legal = 1'b1; has_rd = 1'b1; uses_rs1 = 1'b1; is_load = 1'b1; imm = imm_i;
            end
            OP_OP:     begin legal = 1'b1; has_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_STORE:  begin legal = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm = imm_s; end
            OP_BRANCH: begin legal = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm = imm_b; end
            // fence/system carry no register operands for hazard purposes
            OP_FENCE, OP_SYSTEM: begin legal = 1'b1; has_rd = 1'b1; imm = imm_i; end
            default: ;
         endcase
      end
   end

   assign hz = ex_valid & ex_is_load & (ex_rd != 5'd0) &
               ((uses_rs1 & (rs1 == ex_rd)) | (uses_rs2 & (rs2 == ex_rd)));

   assign if_ready   = rst_n & ((~ex_stall & ~hz) | flush);
   assign rf_p0_addr = rs1;
   assign rf_p1_addr = rs2;
   assign rf_re0     = if_valid & uses_rs1 & ~ex_stall;
   assign rf_re1     = if_valid & uses_rs2 & ~ex_stall;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid    <= 1'b0;
         ex_pc       <= RESET_PC;
         ex_rd       <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_imm      <= '0;
         ex_opcode   <= '0;
         ex_funct3   <= '0;
         ex_funct7b5 <= 1'b0;
         ex_is_load  <= 1'b0;
         ex_illegal  <= 1'b0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (ex_stall) begin
         ex_valid <= ex_valid;
      end else if (hz) begin
         ex_valid <= 1'b0;
      end else if (if_valid) begin
         ex_valid    <= 1'b1;
         ex_pc       <= if_pc;
         ex_rd       <= has_rd ? rd : 5'd0;
         ex_rs1      <= rs1;
         ex_rs2      <= rs2;
         ex_imm      <= imm;
         ex_opcode   <= opc;
         ex_funct3   <= if_instr[14:12];
         ex_funct7b5 <= if_instr[30];
         ex_is_load  <= is_load;
         ex_illegal  <= ~legal;
      end else begin
         ex_valid <= 1'b0;
      end
   end

endmodule
